equ1_pipe: RTL and testbench

EQU1_PIPE -- requirements
Module: equ1_pipe

---
 rtl/equ1_pipe.sv | 108 ++++++++++
 tb/tb_equ1_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/equ1_pipe.sv
// Three-stage 5x5 window gradient: per-row sums, signed weighted row combination,
// then absolute value with saturation. One elastic enable stalls the whole pipe.
module equ1_pipe #(
  parameter int PIXEL_W = 12,
  parameter int GRAD_W  = PIXEL_W + 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [25*PIXEL_W-1:0]      pix_in,
  input  logic                       mode_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5*(PIXEL_W+3)-1:0]   row_sum,
  output logic [GRAD_W-1:0]          grad_out,
  output logic                       sat,
  output logic                       mode_out
);

  localparam int RW = PIXEL_W + 3;
  localparam int SW = PIXEL_W + 6;
  // Clip limit widened to the full signed width so every abs bit feeds the compare.
  localparam logic [SW-1:0] GMAX = {{(SW-GRAD_W){1'b0}}, {GRAD_W{1'b1}}};

  logic en;

  logic [4:0][RW-1:0] s1_row_d, s1_row_q;
  logic               s1_mode_q, s1_valid_q;

  logic signed [SW-1:0] s2_sum_d, s2_sum_q;
  logic [4:0][RW-1:0]   s2_row_q;
  logic                 s2_mode_q, s2_valid_q;

  logic [SW-1:0]        abs_full;
  logic [GRAD_W-1:0]    s3_grad_d, s3_grad_q;
  logic                 s3_sat_d, s3_sat_q;
  logic [4:0][RW-1:0]   s3_row_q;
  logic                 s3_mode_q, s3_valid_q;

  logic signed [SW-1:0] x0, x1, x2, x3, x4;

  assign en       = !s3_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_row_d = '0;
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 5; t++) begin
        s1_row_d[r] = s1_row_d[r] + RW'(pix_in[(5*r+t)*PIXEL_W +: PIXEL_W]);
      end
    end
  end

  always_comb begin
    x0 = $signed({3'b000, s1_row_q[0]});
    x1 = $signed({3'b000, s1_row_q[1]});
    x2 = $signed({3'b000, s1_row_q[2]});
    x3 = $signed({3'b000, s1_row_q[3]});
    x4 = $signed({3'b000, s1_row_q[4]});
    if (s1_mode_q) s2_sum_d = x0 - (x2 <<< 1) + x4;
    else           s2_sum_d = x0 - (x1 <<< 1) + (x3 <<< 1) - x4;
  end

  always_comb begin
    abs_full  = s2_sum_q[SW-1] ? $unsigned(-s2_sum_q) : $unsigned(s2_sum_q);
    s3_sat_d  = abs_full > GMAX;
    s3_grad_d = s3_sat_d ? {GRAD_W{1'b1}} : abs_full[GRAD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_row_q   <= '0;
      s1_mode_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_row_q   <= '0;
      s2_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_grad_q  <= '0;
      s3_sat_q   <= 1'b0;
      s3_row_q   <= '0;
      s3_mode_q  <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (en) begin
      // en doubles as in_ready, so in_valid here is exactly an accepted transfer
      s1_row_q   <= s1_row_d;
      s1_mode_q  <= mode_in;
      s1_valid_q <= in_valid;
      s2_sum_q   <= s2_sum_d;
      s2_row_q   <= s1_row_q;
      s2_mode_q  <= s1_mode_q;
      s2_valid_q <= s1_valid_q;
      s3_grad_q  <= s3_grad_d;
      s3_sat_q   <= s3_sat_d;
      s3_row_q   <= s2_row_q;
      s3_mode_q  <= s2_mode_q;
      s3_valid_q <= s2_valid_q;
    end
  end

  assign out_valid = s3_valid_q;
  assign row_sum   = s3_row_q;
  assign grad_out  = s3_grad_q;
  assign sat       = s3_sat_q;
  assign mode_out  = s3_mode_q;

endmodule

// File: tb/tb_equ1_pipe.sv
// Randomized scoreboard bench for equ1_pipe; two instances share stimulus, one at
// the default gradient width and one at GRAD_W=15 so clipping is exercised.
module tb_equ1_pipe;

  localparam int P  = 12;
  localparam int RW = P + 3;
  localparam int GA = P + 5;
  localparam int GB = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, mode_in, out_ready;
  logic [25*P-1:0] pix_in;

  logic ir_a, ov_a, sat_a, mo_a;
  logic ir_b, ov_b, sat_b, mo_b;
  logic [5*RW-1:0] rs_a, rs_b;
  logic [GA-1:0] g_a;
  logic [GB-1:0] g_b;

  equ1_pipe #(.PIXEL_W(P)) u_a (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(ir_a), .pix_in(pix_in),
    .mode_in(mode_in), .out_valid(ov_a), .out_ready(out_ready), .row_sum(rs_a),
    .grad_out(g_a), .sat(sat_a), .mode_out(mo_a));

  equ1_pipe #(.PIXEL_W(P), .GRAD_W(GB)) u_b (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(ir_b), .pix_in(pix_in),
    .mode_in(mode_in), .out_valid(ov_b), .out_ready(out_ready), .row_sum(rs_b),
    .grad_out(g_b), .sat(sat_b), .mode_out(mo_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][15:0] row;
    logic [31:0]      absv;
    logic             mode;
  } txn_t;

  txn_t q[$];
  int   pixa[25];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  bit   hold_prev = 0;
  logic [5*RW-1:0] prev_rs;
  logic [GA-1:0]   prev_g;
  logic            prev_sat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic txn_t model(input bit md);
    int s[5];
    int w;
    txn_t tr;
    for (int r = 0; r < 5; r++) begin
      s[r] = 0;
      for (int k = 0; k < 5; k++) s[r] += pixa[5*r+k];
      tr.row[r] = 16'(s[r]);
    end
    w = md ? s[0] - 2*s[2] + s[4] : s[0] - 2*s[1] + 2*s[3] - s[4];
    tr.absv = 32'(w < 0 ? -w : w);
    tr.mode = md;
    return tr;
  endfunction

  function automatic logic [63:0] gexp(input logic [31:0] a, input int gw);
    logic [31:0] lim;
    lim = (32'd1 << gw) - 32'd1;
    return 64'(a > lim ? lim : a);
  endfunction

  task automatic set_rows(input int v0, input int v1, input int v2, input int v3, input int v4);
    for (int k = 0; k < 5; k++) begin
      pixa[k] = v0; pixa[5+k] = v1; pixa[10+k] = v2; pixa[15+k] = v3; pixa[20+k] = v4;
    end
  endtask

  task automatic fill_random();
    int kind;
    kind = int'($urandom_range(0, 3));
    for (int i = 0; i < 25; i++) begin
      case (kind)
        0, 1: pixa[i] = int'($urandom_range(0, 4095));
        2:    pixa[i] = 4095;
        default: pixa[i] = ($urandom_range(0, 1) == 1) ? 4095 : 0;
      endcase
    end
    if (kind == 3) begin
      for (int r = 0; r < 5; r++)
        for (int k = 1; k < 5; k++) pixa[5*r+k] = pixa[5*r];
    end
  endtask

  // One cycle: drive, sample #1 later, score handshakes, then advance a full clock.
  task automatic step(input bit iv, input bit md, input bit ordy);
    txn_t tr;
    in_valid = iv; mode_in = md; out_ready = ordy;
    for (int i = 0; i < 25; i++) pix_in[i*P +: P] = 12'(pixa[i]);
    #1;
    if (hold_prev) begin
      chk("hold_valid", 64'(ov_a), 64'd1);
      chk("hold_grad", 64'(g_a), 64'(prev_g));
      chk("hold_sat", 64'(sat_a), 64'(prev_sat));
      for (int r = 0; r < 5; r++) chk("hold_row", 64'(rs_a[r*RW +: RW]), 64'(prev_rs[r*RW +: RW]));
    end
    chk("in_ready", 64'(ir_a), 64'(!ov_a || ordy));
    chk("b_handshake", 64'({ov_b, ir_b}), 64'({ov_a, ir_a}));
    if (ov_a && ordy) begin
      if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else begin
        tr = q.pop_front();
        for (int r = 0; r < 5; r++) begin
          chk("row_a", 64'(rs_a[r*RW +: RW]), 64'(tr.row[r]));
          chk("row_b", 64'(rs_b[r*RW +: RW]), 64'(tr.row[r]));
        end
        chk("grad_a", 64'(g_a), gexp(tr.absv, GA));
        chk("sat_a", 64'(sat_a), 64'(tr.absv > ((32'd1 << GA) - 1)));
        chk("grad_b", 64'(g_b), gexp(tr.absv, GB));
        chk("sat_b", 64'(sat_b), 64'(tr.absv > ((32'd1 << GB) - 1)));
        chk("mode_out", 64'({mo_a, mo_b}), 64'({tr.mode, tr.mode}));
      end
    end
    if (iv && ir_a) begin
      q.push_back(model(md));
      n_acc++;
    end
    hold_prev = ov_a && !ordy;
    prev_rs = rs_a; prev_g = g_a; prev_sat = sat_a;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(0, 0, 1);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed(input bit md, input int r0, input int r1, input int r2, input int r3,
                          input int r4, input int ga, input bit sa, input int gb, input bit sb);
    step(1, md, 1);
    step(0, 0, 1);
    chk("lat_early", 64'(ov_a), 64'd0);
    step(0, 0, 1);
    chk("lat_valid", 64'(ov_a), 64'd1);
    chk("d_row0", 64'(rs_a[0*RW +: RW]), 64'(r0));
    chk("d_row1", 64'(rs_a[1*RW +: RW]), 64'(r1));
    chk("d_row2", 64'(rs_a[2*RW +: RW]), 64'(r2));
    chk("d_row3", 64'(rs_a[3*RW +: RW]), 64'(r3));
    chk("d_row4", 64'(rs_a[4*RW +: RW]), 64'(r4));
    chk("d_grad_a", 64'(g_a), 64'(ga));
    chk("d_sat_a", 64'(sat_a), 64'(sa));
    chk("d_grad_b", 64'(g_b), 64'(gb));
    chk("d_sat_b", 64'(sat_b), 64'(sb));
    chk("d_mode", 64'(mo_a), 64'(md));
    drain();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 64'({ov_a, ov_b}), 64'd0);
    chk({tag, "_rows"}, 64'(rs_a | rs_b), 64'd0);
    chk({tag, "_rows_hi"}, 64'((rs_a | rs_b) >> 64), 64'd0);
    chk({tag, "_grad"}, 64'(g_a) | 64'(g_b), 64'd0);
    chk({tag, "_satmode"}, 64'({sat_a, sat_b, mo_a, mo_b}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; mode_in = 1'b0; out_ready = 1'b0; pix_in = '0;
    for (int i = 0; i < 25; i++) pixa[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_cleared("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(ir_a), 64'd1);
    @(negedge clk);

    set_rows(10, 0, 0, 7, 0);
    directed(0, 50, 0, 0, 35, 0, 120, 0, 120, 0);
    set_rows(0, 4095, 0, 0, 0);
    directed(0, 0, 20475, 0, 0, 0, 40950, 0, 32767, 1);
    set_rows(0, 0, 4095, 0, 0);
    directed(1, 0, 0, 20475, 0, 0, 40950, 0, 32767, 1);
    set_rows(4095, 4095, 4095, 4095, 4095);
    directed(0, 20475, 20475, 20475, 20475, 20475, 0, 0, 0, 0);
    directed(1, 20475, 20475, 20475, 20475, 20475, 0, 0, 0, 0);

    // back-to-back stream with a four-cycle downstream stall in the middle
    for (int i = 0; i < 12; i++) begin
      fill_random();
      step(i < 8, 1'($urandom_range(0, 1)), !(i >= 3 && i < 7));
    end
    drain();

    // reset with three windows in flight
    for (int i = 0; i < 3; i++) begin
      fill_random();
      step(1, 1'($urandom_range(0, 1)), 1);
    end
    chk("inflight", 64'(ov_a), 64'd1);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    check_cleared("mid_rst");
    q.delete();
    hold_prev = 0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(ir_a), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      chk("discarded", 64'(ov_a), 64'd0);
    end

    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      fill_random();
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
      cyc++;
    end
    chk("rand_budget", 64'(n_acc >= 10000), 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
